fp_div_seq: RTL
===============

Name: fp_div_seq

Overview:
Iterative, parametrised IEEE-754-style floating-point divider with a start/done handshake. It replaces the fixed single-precision fpdiv with one generic in exponent and mantissa width. It adds round-to-nearest-even and full special-case handling, and reports IEEE-style status flags. It produces one quotient bit per cycle and sits beside the other FP arithmetic units behind a simple request/response interface.

Parameters:
EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
MAN_W, 23, stored fraction width; word width W = 1+EXP_W+MAN_W.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
start  in  1  request; sampled only while busy=0
a  in  W  dividend, captured on the accepted start edge
b  in  W  divisor, captured on the accepted start edge
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse; result/flags valid in that cycle
result  out  W  quotient; holds until the next done
flags  out  4  {invalid, div_by_zero, overflow, underflow}; hold with result

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset, including mid-operation: state=IDLE, busy=0, done=0, result=0, flags=0, iteration counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: start=1 captures a and b, goes to UNPACK.
  - UNPACK: split fields. A special case goes to ROUND with a preset result. Otherwise load the divider and go to DIVIDE, cnt=Q=MAN_W+3.
  - DIVIDE: one restoring step per cycle; cnt-- each cycle; on cnt==1 go to ROUND.
  - ROUND: normalise, round, pack; register result/flags; done=1; go to IDLE.
- busy = (state != IDLE). done is high only in the cycle after ROUND, when busy is already 0. A start in that same cycle is accepted.
- start while busy=1 is ignored; no queueing.
- Latency, counted from the accepting edge to the edge that raises done:
  - normal operands: MAN_W+5 edges (28 for defaults);
  - special cases: 2 edges.
- Inputs with exp==0 are flushed to signed zero (no subnormal inputs). No subnormal outputs.
- Sign = sa XOR sb for all results except NaN.
- Special cases, in priority order:
  - NaN operand, 0/0 or inf/inf: result = canonical qNaN (exp all-ones, fraction MSB=1, sign 0); invalid=1.
  - finite/0: result = ±inf; div_by_zero=1.
  - inf/finite: result = ±inf; no flag.
  - finite/inf or 0/nonzero: result = ±0; no flag.
- Datapath:
  - Dividend {1,ma}, divisor {1,mb}, each MAN_W+1 bits.
  - Quotient register is Q bits (1 integer bit + MAN_W+2 fraction bits); remainder register is MAN_W+2 bits.
  - Sticky = (final remainder != 0).
  - Exponent is computed signed in EXP_W+2 bits: e = ea - eb + BIAS.
  - If the quotient MSB=0, shift left 1 and decrement e.
  - Take MAN_W fraction bits + guard; fold the remaining bit into sticky.
  - RNE: increment if guard & (sticky | lsb). On mantissa carry-out, shift right and increment e.
- Range, checked after rounding:
  - e >= 2^EXP_W-1: ±inf, overflow=1.
  - e <= 0: ±0, underflow=1.
- Flags are not sticky across operations; each done overwrites all four.

Decomposition:
- Package fp_div_pkg holds:
  - state enum {IDLE, UNPACK, DIVIDE, ROUND};
  - flag struct and bit-index constants;
  - functions for BIAS, W and Q from EXP_W/MAN_W;
  - canonical qNaN / inf / zero constructors, parametrised by width.
- One sub-module: fp_div_round (combinational normalise + RNE + range check + pack), instantiated once by fp_div_seq and unit-testable alone.

Test Plan:
- a=0xC0CCCCCD (-6.4), b=0xBF000000 (-0.5) -> result 0x414CCCCD, flags 0. done exactly 28 cycles after the start edge; busy high for cycles 1..27.
- a=0x40CCCCCD, b=0xBF000000 -> 0xC14CCCCD. Then a=0x3F800000, b=0x40400000 (1/3) -> 0x3EAAAAAB (round-up path). Issue the second start in the done cycle; it must be accepted.
- Specials, each with done after 2 cycles:
  - 0x3F800000/0x00000000 -> 0x7F800000, div_by_zero;
  - 0/0 -> 0x7FC00000, invalid;
  - 0x7F800000/0x7F800000 -> 0x7FC00000, invalid;
  - 0x3F800000/0x7F800000 -> 0x00000000.
- Range: 0x7F000000/0x3E800000 -> 0x7F800000, overflow. 0x00800000/0x40000000 -> 0x00000000, underflow.
- Handshake robustness:
  - start pulsed while busy with different operands -> ignored; the first result is unchanged.
  - rst asserted mid-DIVIDE -> next cycle busy=0, result=0, flags=0, and no done pulse follows.
- Parametrisation: EXP_W=5, MAN_W=10 (half precision): 0x4500/0x3C00 (5.0/1.0) -> 0x4500; 0x3C00/0x4200 (1/3) -> 0x3555. Latency 15 cycles.

Source files
------------

// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types, sizing helpers and special-value constructors for fp_div_seq
package fp_div_pkg;

  typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, ROUND} state_t;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  localparam int FLAG_INVALID     = 3;
  localparam int FLAG_DIV_BY_ZERO = 2;
  localparam int FLAG_OVERFLOW    = 1;
  localparam int FLAG_UNDERFLOW   = 0;

  // Constructors build into a wide word; callers slice down to their own width.
  localparam int FP_MAX_W = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_qlen(input int man_w);
    return man_w + 3;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w;
    v = v | (FP_MAX_W'(1) << (man_w - 1));
    return v;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic s, input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w;
    v = v | (FP_MAX_W'(s) << (exp_w + man_w));
    return v;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_zero(input logic s, input int exp_w, input int man_w);
    return FP_MAX_W'(s) << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_div_round.sv
// rtl/fp_div_round.sv - combinational normalise, round-to-nearest-even, range check and pack
module fp_div_round
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    sign_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic [MAN_W+2:0]        quo_i,
  input  logic                    sticky_i,
  output logic [EXP_W+MAN_W:0]    result_o,
  output fp_flags_t               flags_o
);

  localparam int W = fp_width(EXP_W, MAN_W);
  localparam int Q = fp_qlen(MAN_W);
  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic [W-1:0] INF_MAG  = W'(fp_inf(1'b0, EXP_W, MAN_W));
  localparam logic [W-1:0] ZERO_MAG = W'(fp_zero(1'b0, EXP_W, MAN_W));

  // norm drops the leading one: fraction in [Q-2:2], guard at [1], extra sticky bit at [0]
  logic [Q-2:0]            norm;
  logic signed [EXP_W+1:0] e_norm;
  logic signed [EXP_W+1:0] e_rnd;
  logic [MAN_W+1:0]        mant;
  logic [MAN_W-1:0]        frac;
  logic                    round_up;

  always_comb begin
    if (quo_i[Q-1]) begin
      norm   = quo_i[Q-2:0];
      e_norm = exp_i;
    end else begin
      norm   = {quo_i[Q-3:0], 1'b0};
      e_norm = exp_i - (EXP_W+2)'(1);
    end

    round_up = norm[1] & (norm[0] | sticky_i | norm[2]);
    mant     = {1'b0, 1'b1, norm[Q-2:2]} + {{(MAN_W+1){1'b0}}, round_up};

    if (mant[MAN_W+1]) begin
      e_rnd = e_norm + (EXP_W+2)'(1);
      frac  = mant[MAN_W:1];
    end else begin
      e_rnd = e_norm;
      frac  = mant[MAN_W-1:0];
    end

    flags_o = '0;
    if (e_rnd >= E_MAX) begin
      result_o         = {sign_i, INF_MAG[W-2:0]};
      flags_o.overflow = 1'b1;
    end else if (e_rnd <= 0) begin
      result_o          = {sign_i, ZERO_MAG[W-2:0]};
      flags_o.underflow = 1'b1;
    end else begin
      result_o = {sign_i, e_rnd[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - iterative restoring floating-point divider, one quotient bit per cycle
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int W  = fp_width(EXP_W, MAN_W);
  localparam int Q  = fp_qlen(MAN_W);
  localparam int CW = $clog2(Q + 1);
  localparam logic signed [EXP_W+1:0] BIAS_E = (EXP_W+2)'(fp_bias(EXP_W));
  localparam logic [W-1:0] QNAN     = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0] INF_MAG  = W'(fp_inf(1'b0, EXP_W, MAN_W));
  localparam logic [W-1:0] ZERO_MAG = W'(fp_zero(1'b0, EXP_W, MAN_W));

  state_t           state_q;
  logic [W-1:0]     a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [Q-1:0]     quo_q, quo_d;
  logic [MAN_W+1:0] rem_q, rem_d;
  logic [MAN_W:0]   div_q;
  logic [W-1:0]     result_q;
  fp_flags_t        flags_q;
  logic             done_q;

  // Operands are held in a_q/b_q for the whole operation, so decode stays combinational.
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        ma, mb;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                    sign_r, spec_hit;
  logic [W-1:0]            spec_res;
  fp_flags_t               spec_flags;
  logic signed [EXP_W+1:0] e_calc;

  always_comb begin
    ea     = a_q[W-2 -: EXP_W];
    eb     = b_q[W-2 -: EXP_W];
    ma     = a_q[MAN_W-1:0];
    mb     = b_q[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (ma == '0);
    b_inf  = (&eb) && (mb == '0);
    a_nan  = (&ea) && (ma != '0);
    b_nan  = (&eb) && (mb != '0);
    sign_r = a_q[W-1] ^ b_q[W-1];
    e_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;

    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res           = QNAN;
      spec_flags.invalid = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_res               = {sign_r, INF_MAG[W-2:0]};
      spec_flags.div_by_zero = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_r, INF_MAG[W-2:0]};
    end else if (b_inf || a_zero) begin
      spec_res = {sign_r, ZERO_MAG[W-2:0]};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Restoring step: remainder stays below twice the divisor, so MAN_W+2 bits suffice.
  logic [MAN_W+2:0] diff;
  logic             q_bit;

  always_comb begin
    diff  = {1'b0, rem_q} - {2'b00, div_q};
    q_bit = ~diff[MAN_W+2];
    rem_d = (q_bit ? diff[MAN_W+1:0] : rem_q) << 1;
    quo_d = {quo_q[Q-2:0], q_bit};
  end

  logic [W-1:0] rnd_result;
  fp_flags_t    rnd_flags;

  fp_div_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign_i   (sign_r),
    .exp_i    (e_calc),
    .quo_i    (quo_q),
    .sticky_i (|rem_q),
    .result_o (rnd_result),
    .flags_o  (rnd_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          rem_q <= {1'b0, 1'b1, ma};
          div_q <= {1'b1, mb};
          quo_q <= '0;
          if (spec_hit) begin
            state_q <= ROUND;
          end else begin
            cnt_q   <= CW'(Q);
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ROUND;
        end
        ROUND: begin
          result_q <= spec_hit ? spec_res : rnd_result;
          flags_q  <= spec_hit ? spec_flags : rnd_flags;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule
